sync_fifo_param: RTL and testbench

Single-clock, fully parametrised FIFO that succeeds the dual-clock FIFO for same-domain buffering. It generalises width, depth (non-power-of-two allowed) and read mode (standard or first-word-fall-through). It adds almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. It sits between same-clock producer/consumer stages in the datapath.

---
 rtl/sync_fifo_param.sv | 120 ++++++++++++
 tb/tb_sync_fifo_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO. Supports any depth >= 2, standard or
// first-word-fall-through read mode, almost-full/almost-empty thresholds,
// an occupancy count, sticky overflow/underflow flags and a synchronous flush.
module sync_fifo_param #(
   parameter int WIDTH         = 36,
   parameter int DEPTH         = 1024,
   parameter bit FWFT          = 1'b0,
   parameter int AFULL_THRESH  = DEPTH - 4,
   parameter int AEMPTY_THRESH = 4,
   parameter int CNTW          = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr,
   input  logic [WIDTH-1:0] datain,
   output logic             full,
   output logic             almost_full,
   input  logic             rd,
   output logic [WIDTH-1:0] dataout,
   output logic             empty,
   output logic             almost_empty,
   output logic [CNTW-1:0]  count,
   output logic             overflow,
   output logic             underflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [PW-1:0]    w_wr_ptr_nxt, w_rd_ptr_nxt;
   logic [CNTW-1:0]  r_count, w_count_nxt;
   logic             r_full, r_afull, r_empty, r_aempty, r_ovf, r_udf;
   logic             w_wr_acc, w_rd_acc;

   // Accept decisions use the registered (pre-edge) flags only, so a full
   // FIFO rejects a write even when a read is accepted in the same cycle.
   assign w_wr_acc = wr & ~r_full;
   assign w_rd_acc = rd & ~r_empty;

   // Explicit wrap compare keeps non-power-of-two depths correct.
   assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
   assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

   // Next occupancy; a simultaneous accepted read and write cancel out.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = r_count + CNTW'(1);
         2'b01:   w_count_nxt = r_count - CNTW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Pointers, count, flags derived from next count, sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
         r_empty  <= 1'b1;
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
         r_empty  <= 1'b1;
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= w_wr_ptr_nxt;
         if (w_rd_acc) r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == CNTW'(DEPTH));
         r_afull  <= (w_count_nxt >= CNTW'(AFULL_THRESH));
         r_empty  <= (w_count_nxt == '0);
         r_aempty <= (w_count_nxt <= CNTW'(AEMPTY_THRESH));
         if (wr && r_full)  r_ovf <= 1'b1;
         if (rd && r_empty) r_udf <= 1'b1;
      end
   end

   // Storage write; contents are never reset, writes blocked by flush/reset.
   always_ff @(posedge clk) begin
      if (rst_n && !flush && w_wr_acc) r_mem[r_wr_ptr] <= datain;
   end

   generate
      if (FWFT) begin : g_fwft
         // Head word is presented combinationally; forced to zero while empty
         // so the output is clean out of reset.
         assign dataout = r_empty ? '0 : r_mem[r_rd_ptr];
      end else begin : g_std
         logic [WIDTH-1:0] r_dout;
         // Registered read port: updates only on an accepted read.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                  r_dout <= '0;
            else if (!flush && w_rd_acc) r_dout <= r_mem[r_rd_ptr];
         end
         assign dataout = r_dout;
      end
   endgenerate

   assign full         = r_full;
   assign almost_full  = r_afull;
   assign empty        = r_empty;
   assign almost_empty = r_aempty;
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: standard-mode 1024-deep instance,
// 5-deep non-power-of-two instance, and an 8-deep FWFT instance.
module tb_sync_fifo_param;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   // Instance A: defaults (WIDTH 36, DEPTH 1024, AF 1020, AE 4, standard)
   logic        a_flush = 0, a_wr = 0, a_rd = 0;
   logic [35:0] a_din = '0, a_dout;
   logic        a_full, a_af, a_empty, a_ae, a_ovf, a_udf;
   logic [10:0] a_cnt;

   sync_fifo_param u_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr(a_wr), .datain(a_din),
      .full(a_full), .almost_full(a_af), .rd(a_rd), .dataout(a_dout),
      .empty(a_empty), .almost_empty(a_ae), .count(a_cnt),
      .overflow(a_ovf), .underflow(a_udf));

   // Instance B: DEPTH 5, AF 4, AE 1, 8-bit, standard
   logic       b_flush = 0, b_wr = 0, b_rd = 0;
   logic [7:0] b_din = '0, b_dout;
   logic       b_full, b_af, b_empty, b_ae, b_ovf, b_udf;
   logic [2:0] b_cnt;

   sync_fifo_param #(.WIDTH(8), .DEPTH(5), .FWFT(1'b0), .AFULL_THRESH(4),
                     .AEMPTY_THRESH(1)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr(b_wr), .datain(b_din),
      .full(b_full), .almost_full(b_af), .rd(b_rd), .dataout(b_dout),
      .empty(b_empty), .almost_empty(b_ae), .count(b_cnt),
      .overflow(b_ovf), .underflow(b_udf));

   // Instance C: FWFT, DEPTH 8, 36-bit
   logic        c_flush = 0, c_wr = 0, c_rd = 0;
   logic [35:0] c_din = '0, c_dout;
   logic        c_full, c_af, c_empty, c_ae, c_ovf, c_udf;
   logic [3:0]  c_cnt;

   sync_fifo_param #(.WIDTH(36), .DEPTH(8), .FWFT(1'b1)) u_c (
      .clk(clk), .rst_n(rst_n), .flush(c_flush), .wr(c_wr), .datain(c_din),
      .full(c_full), .almost_full(c_af), .rd(c_rd), .dataout(c_dout),
      .empty(c_empty), .almost_empty(c_ae), .count(c_cnt),
      .overflow(c_ovf), .underflow(c_udf));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and land 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("A rst count", a_cnt, 0);
      chk("A rst empty", a_empty, 1);
      chk("A rst aempty", a_ae, 1);
      chk("A rst full", a_full, 0);
      chk("A rst afull", a_af, 0);
      chk("A rst ovf", a_ovf, 0);
      chk("A rst udf", a_udf, 0);
      chk("A rst dout", a_dout, 0);
      chk("B rst empty", b_empty, 1);
      chk("C rst empty", c_empty, 1);
      chk("C rst dout", c_dout, 0);
      step();
      step();
      #3 rst_n = 1'b1;

      // ---------------- A: fill 1..1024
      step();
      a_wr = 1;
      for (int i = 1; i <= 1024; i++) begin
         a_din = 36'(i);
         step();
         chk("A fill count", a_cnt, i);
         if (i == 4 || i == 5)       chk("A fill aempty", a_ae, (i <= 4));
         if (i == 1019 || i == 1020) chk("A fill afull", a_af, (i >= 1020));
         if (i == 1023 || i == 1024) chk("A fill full", a_full, (i == 1024));
      end
      a_wr = 0;
      chk("A full empty", a_empty, 0);
      chk("A full ovf", a_ovf, 0);
      chk("A full udf", a_udf, 0);

      // ---------------- A: write while full is dropped
      a_wr = 1; a_din = 36'hDEAD;
      step();
      a_wr = 0;
      chk("A ovf count", a_cnt, 1024);
      chk("A ovf flag", a_ovf, 1);
      chk("A ovf full", a_full, 1);

      // ---------------- A: drain, 1-cycle read latency
      a_rd = 1;
      for (int i = 1; i <= 1024; i++) begin
         step();
         chk("A drain data", a_dout, i);
      end
      a_rd = 0;
      chk("A drained empty", a_empty, 1);
      chk("A drained count", a_cnt, 0);
      chk("A drained aempty", a_ae, 1);
      chk("A drained udf", a_udf, 0);

      // ---------------- A: steady state at count 5
      a_wr = 1;
      for (int k = 0; k < 5; k++) begin
         a_din = 36'(100 + k);
         step();
      end
      a_rd = 1;
      for (int k = 0; k < 100; k++) begin
         a_din = 36'(105 + k);
         step();
         chk("A steady count", a_cnt, 5);
         chk("A steady data", a_dout, 100 + k);
      end
      a_wr = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("A tail data", a_dout, 200 + k);
      end
      chk("A tail empty", a_empty, 1);
      chk("A tail udf", a_udf, 0);
      step();
      a_rd = 0;
      chk("A udf flag", a_udf, 1);
      chk("A udf dout hold", a_dout, 204);
      chk("A udf count", a_cnt, 0);

      // ---------------- A: flush with count 300 and overflow still set
      a_wr = 1;
      for (int j = 0; j < 300; j++) begin
         a_din = 36'(1000 + j);
         step();
      end
      a_wr = 0;
      chk("A pre-flush count", a_cnt, 300);
      chk("A pre-flush ovf", a_ovf, 1);
      a_flush = 1; a_wr = 1; a_rd = 1; a_din = 36'h555;
      step();
      a_flush = 0; a_wr = 0; a_rd = 0;
      chk("A flush count", a_cnt, 0);
      chk("A flush empty", a_empty, 1);
      chk("A flush aempty", a_ae, 1);
      chk("A flush full", a_full, 0);
      chk("A flush ovf", a_ovf, 0);
      chk("A flush udf", a_udf, 0);
      chk("A flush dout hold", a_dout, 204);
      a_wr = 1; a_din = 36'h777;
      step();
      a_wr = 0;
      chk("A post-flush count", a_cnt, 1);
      a_rd = 1;
      step();
      a_rd = 0;
      chk("A post-flush data", a_dout, 36'h777);
      chk("A post-flush empty", a_empty, 1);

      // ---------------- B: DEPTH 5, write3/read3 eight times (wraps)
      for (int r = 0; r < 8; r++) begin
         b_wr = 1;
         for (int k = 0; k < 3; k++) begin
            b_din = 8'(r * 3 + k);
            step();
            chk("B w count", b_cnt, k + 1);
            chk("B w aempty", b_ae, (k + 1 <= 1));
            chk("B w afull", b_af, (k + 1 >= 4));
         end
         b_wr = 0; b_rd = 1;
         for (int k = 0; k < 3; k++) begin
            step();
            chk("B r data", b_dout, r * 3 + k);
            chk("B r count", b_cnt, 2 - k);
            chk("B r aempty", b_ae, (2 - k <= 1));
         end
         b_rd = 0;
      end
      b_wr = 1;
      for (int k = 0; k < 5; k++) begin
         b_din = 8'(8'h40 + k);
         step();
         chk("B fill afull", b_af, (k + 1 >= 4));
         chk("B fill full", b_full, (k + 1 == 5));
      end
      b_rd = 1; b_din = 8'hEE;
      step();
      b_wr = 0;
      chk("B full wr+rd count", b_cnt, 4);
      chk("B full wr+rd ovf", b_ovf, 1);
      chk("B full wr+rd data", b_dout, 8'h40);
      chk("B full wr+rd full", b_full, 0);
      for (int k = 1; k < 5; k++) begin
         step();
         chk("B drain data", b_dout, 8'h40 + k);
      end
      b_rd = 0;
      chk("B drain empty", b_empty, 1);
      chk("B drain udf", b_udf, 0);

      // ---------------- C: FWFT
      c_wr = 1; c_din = 36'hA5;
      step();
      c_wr = 0;
      chk("C fwft empty", c_empty, 0);
      chk("C fwft data", c_dout, 36'hA5);
      chk("C fwft count", c_cnt, 1);
      c_wr = 1; c_din = 36'h5A;
      step();
      c_wr = 0;
      chk("C fwft head hold", c_dout, 36'hA5);
      chk("C fwft count2", c_cnt, 2);
      c_rd = 1;
      step();
      chk("C fwft next", c_dout, 36'h5A);
      chk("C fwft not empty", c_empty, 0);
      step();
      c_rd = 0;
      chk("C fwft empty after rd", c_empty, 1);
      chk("C fwft udf clear", c_udf, 0);
      c_wr = 1; c_rd = 1; c_din = 36'h33;
      step();
      c_wr = 0; c_rd = 0;
      chk("C empty wr+rd count", c_cnt, 1);
      chk("C empty wr+rd udf", c_udf, 1);
      chk("C empty wr+rd data", c_dout, 36'h33);

      // ---------------- A: async reset mid-burst, between edges
      a_wr = 1;
      for (int k = 0; k < 3; k++) begin
         a_din = 36'(50 + k);
         step();
      end
      chk("A burst count", a_cnt, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("A midrst count", a_cnt, 0);
      chk("A midrst empty", a_empty, 1);
      chk("A midrst aempty", a_ae, 1);
      chk("A midrst dout", a_dout, 0);
      chk("C midrst count", c_cnt, 0);
      chk("C midrst udf", c_udf, 0);
      step();
      chk("A held rst count", a_cnt, 0);
      #2 rst_n = 1'b1;
      a_din = 36'h99;
      step();
      a_wr = 0;
      chk("A first wr after rst", a_cnt, 1);
      a_rd = 1;
      step();
      a_rd = 0;
      chk("A first data after rst", a_dout, 36'h99);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
      $finish;
   end

endmodule
